param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst_n, which is synchronous and active-low.
REQ-002 Parameter ADDR_WIDTH, default 10: depth width, legal 4-10; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32: data width, legal 1-256.
REQ-004 Parameter READ_MODE, default "STD": "STD" (registered read) or "FWFT" (first-word-fall-through).
REQ-005 Parameter ALMOST_FULL_NUM, default 4: almost_full margin, legal 1 to DEPTH-1.
REQ-006 Parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold, legal 1 to DEPTH-1.
REQ-007 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- clr  in  1  synchronous flush, active high
- wr_data  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  no write accepted this cycle
- almost_full  out  1  level >= DEPTH-ALMOST_FULL_NUM
- overflow  out  1  sticky: write attempted while full
- rd_en  in  1  read request (STD) / pop (FWFT)
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word
- empty  out  1  no read accepted this cycle
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM
- underflow  out  1  sticky: read attempted while empty
- water_level  out  ADDR_WIDTH+1  words held, 0 to DEPTH

Function
REQ-008 Write accepted iff wr_en=1 and full=0; word stored at write pointer, pointer wraps DEPTH-1 -> 0.
REQ-009 Read accepted iff rd_en=1 and empty=0; read pointer wraps DEPTH-1 -> 0.
REQ-010 Pointers SHALL be ADDR_WIDTH+1 bits; full/empty are decided from the extra MSB, never from a DEPTH-1 capacity limit.
REQ-011 All flags and water_level SHALL be registered or decoded only from registered state; no combinational path from wr_en/rd_en to any output.
REQ-012 water_level SHALL change by +1 on a write only, -1 on a read only, and 0 on both or neither; capacity is DEPTH in both modes, including any FWFT output word.
REQ-013 STD: rd_data updates and rd_valid pulses high exactly 1 cycle after an accepted read; rd_data holds its value otherwise.
REQ-014 FWFT: the head word is presented on rd_data with rd_valid=1 whenever empty=0; after an accepted pop, the next word or empty=1 appears on the following cycle.
REQ-015 Latency from a write into an empty FIFO to empty=0 SHALL be 1 cycle in STD and 2 cycles in FWFT.
REQ-016 A simultaneous write and read while full: read accepted, write rejected, overflow set.
REQ-017 A simultaneous write and read while empty: write accepted, read rejected, underflow set.
REQ-018 A simultaneous write and read while neither full nor empty: both accepted, water_level unchanged.
REQ-019 overflow/underflow SHALL remain 1 until clr or reset.
REQ-020 clr=1 SHALL zero pointers, water_level, rd_valid, overflow and underflow next cycle; wr_en/rd_en are ignored that cycle; RAM contents are not cleared.

Reset
REQ-021 With rst_n=0 at a clk edge: full=0, almost_full=0, overflow=0, rd_data=0, rd_valid=0, empty=1, almost_empty=1, underflow=0, water_level=0; pointers 0.
REQ-022 Reset SHALL take priority over clr, wr_en and rd_en; a reset mid-burst discards all stored words; the RAM array is not reset.

Structure
REQ-023 A shared package SHALL hold the READ_MODE string constants and the legal parameter-range limits.
REQ-024 Storage SHALL be one sub-module, sync_fifo_sdpram: single-clock simple dual-port RAM, synchronous write, asynchronous read; flags/pointers live in param_sync_fifo.

Verification (ADDR_WIDTH=4, DEPTH=16, DATA_WIDTH=8, thresholds 4)
REQ-025 Fill: 16 writes 0x00-0x0F -> full=1 after 16th, almost_full=1 from level 12, water_level=16; 17th write -> overflow=1, contents unchanged.
REQ-026 STD drain: 16 reads -> rd_data 0x00-0x0F in order, 1 cycle after each rd_en; almost_empty=1 at level 4; empty=1 at level 0; 17th read -> underflow=1.
REQ-027 FWFT: single write 0xA5 into empty -> rd_data=0xA5, rd_valid=1, empty=0 two cycles later; pop -> empty=1 next cycle.
REQ-028 Wrap: 10 writes, 10 reads, 10 writes, 10 reads with concurrent write+read on 5 cycles -> data order intact, water_level never exceeds 10.
REQ-029 Full+both: at level 16 assert wr_en=rd_en=1 -> level 15, overflow=1; at level 0 both -> level 1, underflow=1.
REQ-030 clr at level 7 with overflow=1 and wr_en=1 -> next cycle level 0, empty=1, overflow=0, no word written; rst_n=0 mid-burst -> all REQ-021 values.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_pkg
// Shared constants for the parameterised synchronous FIFO:
//   - READ_MODE selector strings ("STD" registered read, "FWFT" first-word-
//     fall-through)
//   - legal ranges for the FIFO parameters, plus a helper that checks a
//     complete parameter set at elaboration time
// -----------------------------------------------------------------------------
package param_sync_fifo_pkg;

    localparam string READ_MODE_STD  = "STD";
    localparam string READ_MODE_FWFT = "FWFT";

    localparam int ADDR_WIDTH_MIN = 4;
    localparam int ADDR_WIDTH_MAX = 10;
    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 256;
    // Almost-full margin and almost-empty threshold run from this value up to DEPTH-1.
    localparam int THRESHOLD_MIN  = 1;

    // Returns 1 when the whole parameter set lies inside the supported ranges.
    function automatic bit params_legal(
        input int aw,
        input int dw,
        input int af_num,
        input int ae_num,
        input bit mode_ok
    );
        int depth;
        depth = 1 << aw;
        return mode_ok
            && (aw >= ADDR_WIDTH_MIN) && (aw <= ADDR_WIDTH_MAX)
            && (dw >= DATA_WIDTH_MIN) && (dw <= DATA_WIDTH_MAX)
            && (af_num >= THRESHOLD_MIN) && (af_num <= depth - 1)
            && (ae_num >= THRESHOLD_MIN) && (ae_num <= depth - 1);
    endfunction

endpackage : param_sync_fifo_pkg

// File: rtl/param_sync_fifo_sdpram.sv
// -----------------------------------------------------------------------------
// sync_fifo_sdpram
// Single-clock simple dual-port RAM used as FIFO storage.
// Synchronous write, asynchronous (combinational) read. The array has no
// reset: its contents are only meaningful between the FIFO pointers.
//
// Ports:
//   clk_i    in  1           clock, rising edge
//   we_i     in  1           write enable
//   waddr_i  in  ADDR_WIDTH  write address
//   wdata_i  in  DATA_WIDTH  write data
//   raddr_i  in  ADDR_WIDTH  read address
//   rdata_o  out DATA_WIDTH  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module sync_fifo_sdpram
    import param_sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write port; deliberately not reset so it maps onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : sync_fifo_sdpram

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Parameterised single-clock FIFO with STD (registered read) or FWFT
// (first-word-fall-through) read port. All flags and the fill level are
// registered; nothing combinational runs from wr_en/rd_en to an output.
//
// Pointers are ADDR_WIDTH+1 bits so the full DEPTH words can be held: equal
// pointers mean empty, pointers differing only in the extra MSB mean full.
//
// In FWFT mode the head word lives in the rd_data register. Three pointers
// are kept: wr_ptr (next slot to write), pop_ptr (words consumed by the user)
// and fetch_ptr (next RAM slot to copy into the head register). The level
// and full flag use wr_ptr - pop_ptr, so the head word counts toward capacity
// and its RAM slot cannot be overwritten before it is popped.
//
// Ports:
//   clk           in  1             clock, rising edge
//   rst_n         in  1             synchronous active-low reset
//   clr           in  1             synchronous flush, active high
//   wr_data       in  DATA_WIDTH    write data
//   wr_en         in  1             write request
//   full          out 1             no write accepted this cycle
//   almost_full   out 1             level >= DEPTH-ALMOST_FULL_NUM
//   overflow      out 1             sticky: write attempted while full
//   rd_en         in  1             read request (STD) / pop (FWFT)
//   rd_data       out DATA_WIDTH    read data
//   rd_valid      out 1             rd_data holds a valid word
//   empty         out 1             no read accepted this cycle
//   almost_empty  out 1             level <= ALMOST_EMPTY_NUM
//   underflow     out 1             sticky: read attempted while empty
//   water_level   out ADDR_WIDTH+1  words held, 0 to DEPTH
// -----------------------------------------------------------------------------
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int    ADDR_WIDTH       = 10,
    parameter int    DATA_WIDTH       = 32,
    parameter string READ_MODE        = "STD",
    parameter int    ALMOST_FULL_NUM  = 4,
    parameter int    ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   water_level
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit IS_FWFT = (READ_MODE == READ_MODE_FWFT);
    localparam bit IS_STD  = (READ_MODE == READ_MODE_STD);
    localparam bit PARAMS_OK = params_legal(ADDR_WIDTH, DATA_WIDTH, ALMOST_FULL_NUM,
                                            ALMOST_EMPTY_NUM, IS_FWFT || IS_STD);

    localparam logic [ADDR_WIDTH:0] PTR_ZERO = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_NUM);

    // Refuse to elaborate an unsupported configuration.
    if (!PARAMS_OK) begin : g_param_check
        $error("param_sync_fifo: parameter set outside the supported range");
    end

    // Full: same slot index, opposite lap.
    function automatic logic ptr_full(input logic [ADDR_WIDTH:0] w, input logic [ADDR_WIDTH:0] r);
        return (w[ADDR_WIDTH] != r[ADDR_WIDTH]) && (w[ADDR_WIDTH-1:0] == r[ADDR_WIDTH-1:0]);
    endfunction

    // Empty: identical pointers, same lap.
    function automatic logic ptr_empty(input logic [ADDR_WIDTH:0] w, input logic [ADDR_WIDTH:0] r);
        return (w == r);
    endfunction

    logic [ADDR_WIDTH:0]   wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH:0]   pop_ptr_q,   pop_ptr_d;
    logic [ADDR_WIDTH:0]   fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_WIDTH:0]   level_q,     level_d;
    logic                  full_q,      full_d;
    logic                  empty_q,     empty_d;
    logic                  afull_q,     afull_d;
    logic                  aempty_q,    aempty_d;
    logic                  ovf_q,       ovf_d;
    logic                  udf_q,       udf_d;
    logic                  rd_valid_q,  rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;

    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  ram_has_s;
    logic                  load_s;
    logic [ADDR_WIDTH-1:0] ram_raddr_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    // STD reads the slot being consumed; FWFT prefetches the slot behind the head word.
    assign ram_raddr_s = IS_FWFT ? fetch_ptr_q[ADDR_WIDTH-1:0] : pop_ptr_q[ADDR_WIDTH-1:0];

    sync_fifo_sdpram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .raddr_i (ram_raddr_s),
        .rdata_o (ram_rdata_s)
    );

    // Accept decode from registered flags; clr masks both requests.
    always_comb begin
        wr_acc_s  = 1'b0;
        rd_acc_s  = 1'b0;
        load_s    = 1'b0;
        ram_has_s = (fetch_ptr_q != wr_ptr_q);
        if (!clr) begin
            wr_acc_s = wr_en & ~full_q;
            rd_acc_s = rd_en & ~empty_q;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
        // Refill the head register when it is free or being popped. Only words
        // written on earlier cycles qualify, giving FWFT its two-cycle latency.
        if (IS_FWFT && !clr) begin
            load_s = ram_has_s & (~rd_valid_q | rd_acc_s);
        end else begin
            load_s = 1'b0;
        end
    end

    // Next-state for pointers, read port, sticky errors and registered flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        pop_ptr_d   = pop_ptr_q;
        fetch_ptr_d = fetch_ptr_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;

        if (clr) begin
            // Flush: RAM contents stay, rd_data keeps its last value but is invalid.
            wr_ptr_d    = PTR_ZERO;
            pop_ptr_d   = PTR_ZERO;
            fetch_ptr_d = PTR_ZERO;
            rd_valid_d  = 1'b0;
            ovf_d       = 1'b0;
            udf_d       = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                pop_ptr_d = pop_ptr_q + PTR_ONE;
            end else begin
                pop_ptr_d = pop_ptr_q;
            end

            if (IS_FWFT) begin
                if (load_s) begin
                    fetch_ptr_d = fetch_ptr_q + PTR_ONE;
                    rd_valid_d  = 1'b1;
                    rd_data_d   = ram_rdata_s;
                end else if (rd_acc_s) begin
                    rd_valid_d  = 1'b0;
                end else begin
                    rd_valid_d  = rd_valid_q;
                end
            end else begin
                // fetch_ptr is idle in STD; keep it tracking pop_ptr.
                fetch_ptr_d = pop_ptr_d;
                rd_valid_d  = rd_acc_s;
                if (rd_acc_s) begin
                    rd_data_d = ram_rdata_s;
                end else begin
                    rd_data_d = rd_data_q;
                end
            end

            ovf_d = ovf_q | (wr_en & full_q);
            udf_d = udf_q | (rd_en & empty_q);
        end

        level_d = wr_ptr_d - pop_ptr_d;
        full_d  = ptr_full(wr_ptr_d, pop_ptr_d);
        if (IS_FWFT) begin
            empty_d = ~rd_valid_d;
        end else begin
            empty_d = ptr_empty(wr_ptr_d, pop_ptr_d);
        end
        afull_d  = (level_d >= AF_LEVEL);
        aempty_d = (level_d <= AE_LEVEL);
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= PTR_ZERO;
            pop_ptr_q   <= PTR_ZERO;
            fetch_ptr_q <= PTR_ZERO;
            level_q     <= PTR_ZERO;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            pop_ptr_q   <= pop_ptr_d;
            fetch_ptr_q <= fetch_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign underflow    = udf_q;
    assign water_level  = level_q;

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
// Directed self-checking bench: one STD instance and one FWFT instance of
// param_sync_fifo (ADDR_WIDTH=4, DATA_WIDTH=8, thresholds 4). Inputs change
// 1 time unit after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] f_wr_data;
    logic       f_wr_en;
    logic       f_rd_en;

    logic       full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
    logic [7:0] rd_data;
    logic [4:0] water_level;
    logic       f_full, f_almost_full, f_overflow, f_rd_valid, f_empty, f_almost_empty, f_underflow;
    logic [7:0] f_rd_data;
    logic [4:0] f_water_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_MODE("STD"),
        .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_data(wr_data), .wr_en(wr_en), .full(full), .almost_full(almost_full),
        .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .almost_empty(almost_empty), .underflow(underflow),
        .water_level(water_level)
    );

    param_sync_fifo #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_MODE("FWFT"),
        .ALMOST_FULL_NUM(4), .ALMOST_EMPTY_NUM(4)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_data(f_wr_data), .wr_en(f_wr_en), .full(f_full), .almost_full(f_almost_full),
        .overflow(f_overflow), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .empty(f_empty), .almost_empty(f_almost_empty), .underflow(f_underflow),
        .water_level(f_water_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_std_reset(input string tag);
        chk({tag, "_full"},   32'(full),         32'd0);
        chk({tag, "_afull"},  32'(almost_full),  32'd0);
        chk({tag, "_ovf"},    32'(overflow),     32'd0);
        chk({tag, "_rdata"},  32'(rd_data),      32'd0);
        chk({tag, "_rvalid"}, 32'(rd_valid),     32'd0);
        chk({tag, "_empty"},  32'(empty),        32'd1);
        chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_udf"},    32'(underflow),    32'd0);
        chk({tag, "_level"},  32'(water_level),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;

        // Reset values
        tick(); tick();
        chk_std_reset("rst");
        chk("rst_f_empty", 32'(f_empty), 32'd1);
        chk("rst_f_level", 32'(f_water_level), 32'd0);
        rst_n = 1'b1;

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            chk("fill_level", 32'(water_level), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
            chk("fill_full",  32'(full),        32'((i + 1) == 16));
            chk("fill_empty", 32'(empty),       32'd0);
        end
        // 17th write is rejected and flags overflow
        wr_data = 8'hEE;
        tick();
        chk("ovf_set",   32'(overflow),    32'd1);
        chk("ovf_level", 32'(water_level), 32'd16);
        chk("ovf_full",  32'(full),        32'd1);
        wr_en = 1'b0;

        // Drain in order, data one cycle after each read
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_rvalid", 32'(rd_valid),     32'd1);
            chk("drain_data",   32'(rd_data),      32'(i));
            chk("drain_level",  32'(water_level),  32'(15 - i));
            chk("drain_aempty", 32'(almost_empty), 32'((15 - i) <= 4));
            chk("drain_empty",  32'(empty),        32'((15 - i) == 0));
        end
        rd_en = 1'b0;
        tick();
        chk("idle_rvalid", 32'(rd_valid), 32'd0);
        chk("idle_hold",   32'(rd_data),  32'h0F);
        // 17th read
        rd_en = 1'b1;
        tick();
        chk("udf_set",    32'(underflow), 32'd1);
        chk("udf_rvalid", 32'(rd_valid),  32'd0);
        chk("udf_empty",  32'(empty),     32'd1);
        rd_en = 1'b0;

        // Level 7 with both sticky errors, then clr together with a write
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h70 + i);
            tick();
        end
        chk("pre_clr_level", 32'(water_level), 32'd7);
        chk("ovf_sticky",    32'(overflow),    32'd1);
        clr = 1'b1; wr_data = 8'h77;
        tick();
        chk("clr_level",  32'(water_level), 32'd0);
        chk("clr_empty",  32'(empty),       32'd1);
        chk("clr_ovf",    32'(overflow),    32'd0);
        chk("clr_udf",    32'(underflow),   32'd0);
        chk("clr_rvalid", 32'(rd_valid),    32'd0);
        clr = 1'b0; wr_data = 8'h42;
        tick();
        chk("post_clr_level", 32'(water_level), 32'd1);
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        chk("post_clr_data",  32'(rd_data),     32'h42);
        chk("post_clr_empty", 32'(water_level), 32'd0);
        rd_en = 1'b0;

        // Wrap: 10 in, 10 out, 10 in, 10 out with 5 concurrent writes
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
            chk("wrap_w1_level", 32'(water_level), 32'(i + 1));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1;
            tick();
            chk("wrap_r1_data",  32'(rd_data),     32'(8'h10 + i));
            chk("wrap_r1_level", 32'(water_level), 32'(9 - i));
        end
        rd_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            tick();
            chk("wrap_w2_level", 32'(water_level), 32'(i + 1));
        end
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1;
            wr_en = (i < 5);
            wr_data = 8'(8'h30 + i);
            tick();
            chk("wrap_r2_data",  32'(rd_data),     32'(8'h20 + i));
            chk("wrap_r2_level", 32'(water_level), (i < 5) ? 32'd10 : 32'(14 - i));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wrap_r3_data",  32'(rd_data),     32'(8'h30 + i));
            chk("wrap_r3_level", 32'(water_level), 32'(4 - i));
        end
        rd_en = 1'b0;

        // Both requests while full, then both while empty
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            tick();
        end
        chk("both_pre_full", 32'(full),     32'd1);
        chk("both_pre_ovf",  32'(overflow), 32'd0);
        rd_en = 1'b1; wr_data = 8'h99;
        tick();
        chk("both_full_level", 32'(water_level), 32'd15);
        chk("both_full_ovf",   32'(overflow),    32'd1);
        chk("both_full_data",  32'(rd_data),     32'h80);
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("both_drain_data", 32'(rd_data), 32'(8'h81 + i));
        end
        chk("both_pre_empty", 32'(empty),     32'd1);
        chk("both_pre_udf",   32'(underflow), 32'd0);
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        chk("both_empty_level",  32'(water_level), 32'd1);
        chk("both_empty_udf",    32'(underflow),   32'd1);
        chk("both_empty_rvalid", 32'(rd_valid),    32'd0);
        chk("both_empty_empty",  32'(empty),       32'd0);
        wr_en = 1'b0;
        tick();
        chk("both_empty_data", 32'(rd_data), 32'h5A);
        rd_en = 1'b0;

        // Reset mid-burst wins over clr/wr_en/rd_en
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            tick();
        end
        rst_n = 1'b0; rd_en = 1'b1; clr = 1'b1;
        tick();
        chk_std_reset("midrst");
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        tick();
        chk("postrst_level", 32'(water_level), 32'd0);
        chk("postrst_empty", 32'(empty),       32'd1);

        // FWFT: single write becomes visible two cycles later
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        tick();
        chk("fwft_e1_empty", 32'(f_empty),       32'd1);
        chk("fwft_e1_level", 32'(f_water_level), 32'd1);
        f_wr_en = 1'b0;
        tick();
        chk("fwft_e2_empty",  32'(f_empty),    32'd0);
        chk("fwft_e2_rvalid", 32'(f_rd_valid), 32'd1);
        chk("fwft_e2_data",   32'(f_rd_data),  32'hA5);
        f_rd_en = 1'b1;
        tick();
        chk("fwft_pop_empty",  32'(f_empty),       32'd1);
        chk("fwft_pop_rvalid", 32'(f_rd_valid),    32'd0);
        chk("fwft_pop_level",  32'(f_water_level), 32'd0);
        f_rd_en = 1'b0;

        // FWFT capacity is DEPTH including the head word
        for (int i = 0; i < 16; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'(8'h60 + i);
            tick();
            chk("fwft_fill_level", 32'(f_water_level), 32'(i + 1));
        end
        chk("fwft_full", 32'(f_full), 32'd1);
        f_wr_data = 8'hEE;
        tick();
        chk("fwft_ovf", 32'(f_overflow), 32'd1);
        f_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("fwft_head_data",  32'(f_rd_data),  32'(8'h60 + i));
            chk("fwft_head_valid", 32'(f_rd_valid), 32'd1);
            f_rd_en = 1'b1;
            tick();
        end
        f_rd_en = 1'b0;
        chk("fwft_drain_empty", 32'(f_empty),       32'd1);
        chk("fwft_drain_level", 32'(f_water_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_param_sync_fifo
